mem_forward_buffer: RTL and testbench

Parametrised MEM-stage store-data forwarding unit with a retired-write history. Compares each MEM-stage source register against the instruction currently in WB and against the last DEPTH retired register writes held in a shift buffer. This covers register files without write-through and multi-port MEM stages. Sits between the WB write port and the MEM-stage store-data muxes. Produces a per-port forward select plus the forwarded data and its source.

---
 rtl/mem_forward_buffer.sv | 93 +++++++++
 tb/tb_mem_forward_buffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_forward_buffer.sv
// MEM-stage store-data forwarding unit: matches MEM source registers against WB and a DEPTH-entry retired-write history.
// Optional feature macro: MEM_FWD_HITCNT_EN adds a saturating 16-bit hit_count output.
module mem_forward_buffer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int PORTS  = 1,
    parameter int SRC_W  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      reg_write_wb,
    input  logic [ADDR_W-1:0]         reg_w_addr_wb,
    input  logic [DATA_W-1:0]         reg_w_data_wb,
    input  logic                      advance,
    input  logic                      flush,
    input  logic [PORTS*ADDR_W-1:0]   rd_addr_mem,
`ifdef MEM_FWD_HITCNT_EN
    output logic [15:0]               hit_count,
`endif
    output logic [PORTS-1:0]          forward,
    output logic [PORTS*DATA_W-1:0]   fwd_data,
    output logic [PORTS*SRC_W-1:0]    fwd_src
);

    // Index 0 holds entry1 (newest retired write), index DEPTH-1 the oldest.
    logic [DEPTH-1:0]  hist_vld;
    logic [ADDR_W-1:0] hist_addr [DEPTH];
    logic [DATA_W-1:0] hist_data [DEPTH];

    logic push_vld;
    assign push_vld = reg_write_wb && (reg_w_addr_wb != '0);

    // Only the valid bits are reset; address/data are qualified by them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_vld <= '0;
        end else if (flush) begin
            hist_vld <= '0;
        end else if (advance) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                hist_vld[k] <= hist_vld[k-1];
            end
            hist_vld[0] <= push_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (advance && !flush) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                hist_addr[k] <= hist_addr[k-1];
                hist_data[k] <= hist_data[k-1];
            end
            hist_addr[0] <= reg_w_addr_wb;
            hist_data[0] <= reg_w_data_wb;
        end
    end

    // Walk candidates from lowest to highest priority so the newest match overwrites older ones.
    always_comb begin
        forward  = '0;
        fwd_data = '0;
        fwd_src  = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (!rst && (rd_addr_mem[p*ADDR_W +: ADDR_W] != '0)) begin
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (hist_vld[k] && (hist_addr[k] == rd_addr_mem[p*ADDR_W +: ADDR_W])) begin
                        forward[p]                 = 1'b1;
                        fwd_data[p*DATA_W +: DATA_W] = hist_data[k];
                        fwd_src[p*SRC_W +: SRC_W]    = SRC_W'(k + 1);
                    end
                end
                if (reg_write_wb && (reg_w_addr_wb == rd_addr_mem[p*ADDR_W +: ADDR_W])) begin
                    forward[p]                 = 1'b1;
                    fwd_data[p*DATA_W +: DATA_W] = reg_w_data_wb;
                    fwd_src[p*SRC_W +: SRC_W]    = '0;
                end
            end
        end
    end

`ifdef MEM_FWD_HITCNT_EN
    // Counts advancing cycles with any forward; survives flush, saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count <= '0;
        end else if (advance && (|forward) && (hit_count != 16'hFFFF)) begin
            hit_count <= hit_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_forward_buffer.sv
// Directed bench for mem_forward_buffer (DEPTH=2, PORTS=2) with a queue-based reference model.
module tb_mem_forward_buffer;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int D  = 2;
    localparam int P  = 2;
    localparam int SW = 3;

    logic          clk;
    logic          rst;
    logic          reg_write_wb;
    logic [AW-1:0] reg_w_addr_wb;
    logic [DW-1:0] reg_w_data_wb;
    logic          advance;
    logic          flush;
    logic [P*AW-1:0] rd_addr_mem;
    logic [P-1:0]    forward;
    logic [P*DW-1:0] fwd_data;
    logic [P*SW-1:0] fwd_src;
`ifdef MEM_FWD_HITCNT_EN
    logic [15:0]     hit_count;
    int unsigned     m_hits;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    mem_forward_buffer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D), .PORTS(P), .SRC_W(SW)) dut (
        .clk(clk), .rst(rst),
        .reg_write_wb(reg_write_wb), .reg_w_addr_wb(reg_w_addr_wb), .reg_w_data_wb(reg_w_data_wb),
        .advance(advance), .flush(flush), .rd_addr_mem(rd_addr_mem),
`ifdef MEM_FWD_HITCNT_EN
        .hit_count(hit_count),
`endif
        .forward(forward), .fwd_data(fwd_data), .fwd_src(fwd_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: newest retired write at the front of the queue.
    typedef struct packed {
        logic          v;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;
    ent_t hist[$];

    function automatic void model_exp(input int p, output logic f, output logic [DW-1:0] d,
                                      output logic [SW-1:0] s);
        logic [AW-1:0] a;
        a = rd_addr_mem[p*AW +: AW];
        f = 1'b0; d = '0; s = '0;
        if (rst || a == 0) return;
        if (reg_write_wb && reg_w_addr_wb == a) begin
            f = 1'b1; d = reg_w_data_wb; s = '0;
            return;
        end
        for (int i = 0; i < hist.size(); i++) begin
            if (hist[i].v && hist[i].a == a) begin
                f = 1'b1; d = hist[i].d; s = SW'(i + 1);
                return;
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
`ifdef MEM_FWD_HITCNT_EN
            m_hits = 0;
`endif
        end else begin
`ifdef MEM_FWD_HITCNT_EN
            begin
                logic any, f;
                logic [DW-1:0] d;
                logic [SW-1:0] s;
                any = 1'b0;
                for (int p = 0; p < P; p++) begin
                    model_exp(p, f, d, s);
                    any = any | f;
                end
                if (advance && any && m_hits < 16'hFFFF) m_hits++;
            end
`endif
            if (flush) begin
                hist.delete();
            end else if (advance) begin
                hist.push_front('{v: reg_write_wb && reg_w_addr_wb != 0, a: reg_w_addr_wb, d: reg_w_data_wb});
                if (hist.size() > D) void'(hist.pop_back());
            end
        end
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Continuous comparison against the model on every cycle.
    always @(negedge clk) begin
        logic f;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        for (int p = 0; p < P; p++) begin
            model_exp(p, f, d, s);
            chk($sformatf("model_fwd_p%0d", p), DW'(forward[p]), DW'(f));
            chk($sformatf("model_data_p%0d", p), fwd_data[p*DW +: DW], d);
            chk($sformatf("model_src_p%0d", p), DW'(fwd_src[p*SW +: SW]), DW'(s));
        end
`ifdef MEM_FWD_HITCNT_EN
        chk("model_hit_count", DW'(hit_count), DW'(m_hits));
`endif
    end

    task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic adv, input logic fl, input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        @(posedge clk);
        #1;
        reg_write_wb = we; reg_w_addr_wb = wa; reg_w_data_wb = wd;
        advance = adv; flush = fl; rd_addr_mem = {r1, r0};
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input int p, input logic f, input logic [DW-1:0] d,
                       input logic [SW-1:0] s);
        chk({nm, "_fwd"}, DW'(forward[p]), DW'(f));
        chk({nm, "_data"}, fwd_data[p*DW +: DW], d);
        chk({nm, "_src"}, DW'(fwd_src[p*SW +: SW]), DW'(s));
    endtask

    initial begin
        rst = 1'b1;
        reg_write_wb = 1'b1; reg_w_addr_wb = 5'd8; reg_w_data_wb = 32'hDEADBEEF;
        advance = 1'b0; flush = 1'b0; rd_addr_mem = {5'd0, 5'd8};
        @(negedge clk);
        #1;
        lit("reset_gate", 0, 1'b0, 32'h0, 3'd0);
`ifdef MEM_FWD_HITCNT_EN
        chk("hit_count_reset", DW'(hit_count), 32'h0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        // WB-stage match
        cyc(1, 8, 32'hDEADBEEF, 0, 0, 8, 0);
        lit("wb_match", 0, 1, 32'hDEADBEEF, 0);
        lit("wb_idle_port", 1, 0, 32'h0, 0);

        // History aging
        cyc(1, 5, 32'h11, 1, 0, 5, 0);
        lit("age_wb", 0, 1, 32'h11, 0);
        cyc(1, 6, 32'h22, 1, 0, 5, 0);
        lit("age_e1", 0, 1, 32'h11, 1);
        cyc(1, 10, 32'h33, 1, 0, 5, 0);
        lit("age_e2", 0, 1, 32'h11, 2);
        cyc(0, 0, 0, 0, 0, 5, 0);
        lit("age_gone", 0, 0, 32'h0, 0);

        // Newest wins
        cyc(1, 3, 32'hA, 1, 0, 3, 0);
        cyc(1, 3, 32'hB, 1, 0, 3, 0);
        cyc(1, 3, 32'hC, 0, 0, 3, 0);
        lit("newest_wb", 0, 1, 32'hC, 0);
        cyc(0, 3, 32'hC, 0, 0, 3, 0);
        lit("newest_e1", 0, 1, 32'hB, 1);

        // Stall holds entry1
        cyc(1, 7, 32'h7, 1, 0, 7, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0, 7, 0);
            lit($sformatf("stall_%0d", i), 0, 1, 32'h7, 1);
        end

        // Flush: WB match still live in the flush cycle, history empty after
        cyc(1, 7, 32'h77, 1, 1, 7, 0);
        lit("flush_cycle_wb", 0, 1, 32'h77, 0);
        cyc(0, 0, 0, 0, 0, 7, 0);
        lit("flush_after", 0, 0, 32'h0, 0);

        // r0 never forwards
        cyc(1, 0, 32'h55, 1, 0, 0, 0);
        lit("r0_wb_p0", 0, 0, 32'h0, 0);
        lit("r0_wb_p1", 1, 0, 32'h0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        lit("r0_hist", 0, 0, 32'h0, 0);

        // Multi-port
        cyc(1, 4, 32'h44, 1, 0, 0, 0);
        cyc(1, 12, 32'h12, 1, 0, 0, 0);
        cyc(1, 9, 32'h99, 0, 0, 4, 9);
        lit("mp_e2", 0, 1, 32'h44, 2);
        lit("mp_wb", 1, 1, 32'h99, 0);
        cyc(0, 0, 0, 0, 0, 12, 12);
        lit("mp_same_p0", 0, 1, 32'h12, 1);
        lit("mp_same_p1", 1, 1, 32'h12, 1);

        // Asynchronous reset mid-cycle
        cyc(1, 9, 32'h99, 0, 0, 4, 9);
        #2 rst = 1'b1;
        #1;
        lit("arst_p0", 0, 0, 32'h0, 0);
        lit("arst_p1", 1, 0, 32'h0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 4, 12);
        lit("arst_hist_p0", 0, 0, 32'h0, 0);
        lit("arst_hist_p1", 1, 0, 32'h0, 0);

`ifdef MEM_FWD_HITCNT_EN
        cyc(1, 8, 32'h1, 1, 0, 8, 0);
        repeat (70000) @(posedge clk);
        @(negedge clk);
        #1;
        chk("hit_count_sat", DW'(hit_count), 32'h0000FFFF);
`endif

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
